// File: rtl/adder_rr_arbiter_pkg.sv
// Shared constants, types and the round-robin pick function for the
// shared-adder arbiter.
//   NB_BITS : operand width; results are NB_BITS+1 bits {cout, sum}
//   N_REQ   : number of requesters (>= 2, power of 2)
//   ID_W    : requester index width
package adder_arb_pkg;

   localparam int NB_BITS = 16;
   localparam int N_REQ   = 4;
   localparam int ID_W    = $clog2(N_REQ);

   typedef struct packed {
      logic            found;
      logic [ID_W-1:0] idx;
   } pick_t;

   // Scans from ptr upward, wrapping mod N_REQ. Because N_REQ is a power of 2,
   // the wrap comes free from ID_W-bit overflow. The loop runs from the far
   // end backwards, so the nearest set bit is the last one written.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                     input logic [ID_W-1:0]  ptr);
      pick_t           r;
      logic [ID_W-1:0] idx;
      r = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         idx = ptr + ID_W'(i);
         if (valid[idx]) begin
            r.found = 1'b1;
            r.idx   = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Request/response bundle between the datapath clients and the arbiter.
//   i_req_valid/i_req_a/i_req_b/i_req_cin : per-requester requests (packed)
//   o_req_ready                           : one-hot grant
//   o_rsp_valid/o_rsp_id/o_rsp_sum        : response stream
//   i_rsp_ready                           : response backpressure
// slave = arbiter side, master = client/downstream side.
interface adder_rr_arbiter_if;
   import adder_arb_pkg::*;

   logic [N_REQ-1:0]         i_req_valid;
   logic [N_REQ*NB_BITS-1:0] i_req_a;
   logic [N_REQ*NB_BITS-1:0] i_req_b;
   logic [N_REQ-1:0]         i_req_cin;
   logic [N_REQ-1:0]         o_req_ready;
   logic                     o_rsp_valid;
   logic [ID_W-1:0]          o_rsp_id;
   logic [NB_BITS:0]         o_rsp_sum;
   logic                     i_rsp_ready;

   modport slave (
      input  i_req_valid, i_req_a, i_req_b, i_req_cin, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum
   );

   modport master (
      output i_req_valid, i_req_a, i_req_b, i_req_cin, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum
   );

endinterface

// File: rtl/adder_rr_arbiter_core.sv
// Registered adder: {cout_r, sum_r} <= a + b + cin when en is high.
//   clk, rst_n : clock, async active-low reset (clears the result)
//   en         : load strobe
//   a, b, cin  : operands
//   sum_r      : registered sum
//   cout_r     : registered carry-out
module adder_core
   import adder_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NB_BITS-1:0] a,
   input  logic [NB_BITS-1:0] b,
   input  logic               cin,
   output logic [NB_BITS-1:0] sum_r,
   output logic               cout_r
);

   logic [NB_BITS:0] sum_full;

   assign sum_full = {1'b0, a} + {1'b0, b} + {{NB_BITS{1'b0}}, cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else if (en) begin
         sum_r  <= sum_full[NB_BITS-1:0];
         cout_r <= sum_full[NB_BITS];
      end
   end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one registered adder among N_REQ requesters.
//   clk   : clock, rising edge
//   rst_n : async active-low reset; clears the response and pointer at once
//   bus   : slave side of adder_rr_arbiter_if (requests, grant, response)
// A grant is combinational from i_req_valid and i_rsp_ready. The result
// appears one cycle after the accept. A pending response that is not
// accepted downstream blocks all new grants.
module adder_rr_arbiter
   import adder_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   adder_rr_arbiter_if.slave bus
);

   logic [ID_W-1:0]    ptr;
   logic               rsp_valid;
   logic [ID_W-1:0]    rsp_id;
   logic               stall;
   pick_t              pick;
   logic [N_REQ-1:0]   grant;
   logic               accept;
   logic [NB_BITS-1:0] a_sel;
   logic [NB_BITS-1:0] b_sel;
   logic               cin_sel;
   logic [NB_BITS-1:0] sum_r;
   logic               cout_r;

   assign stall = rsp_valid & ~bus.i_rsp_ready;
   assign pick  = rr_pick(bus.i_req_valid, ptr);

   always_comb begin
      grant = '0;
      if (!stall && pick.found) begin
         grant[pick.idx] = 1'b1;
      end
   end

   // A grant is only issued to a valid requester, so any grant is an accept.
   assign accept = |grant;

   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick.idx == ID_W'(k)) begin
            a_sel   = bus.i_req_a[k*NB_BITS +: NB_BITS];
            b_sel   = bus.i_req_b[k*NB_BITS +: NB_BITS];
            cin_sel = bus.i_req_cin[k];
         end
      end
   end

   adder_core u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (accept),
      .a      (a_sel),
      .b      (b_sel),
      .cin    (cin_sel),
      .sum_r  (sum_r),
      .cout_r (cout_r)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
      end else begin
         if (accept) begin
            ptr       <= pick.idx + ID_W'(1);
            rsp_valid <= 1'b1;
            rsp_id    <= pick.idx;
         end else if (!stall) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   assign bus.o_req_ready = grant;
   assign bus.o_rsp_valid = rsp_valid;
   assign bus.o_rsp_id    = rsp_id;
   assign bus.o_rsp_sum   = {cout_r, sum_r};

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;
   import adder_arb_pkg::*;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic [NB_BITS:0] sum;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   adder_rr_arbiter_if bus();

   adder_rr_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t q[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   mptr  = 0;
   logic mvalid = 1'b0;
   int   last_grant = -1;
   int   n_acc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_req();
      bus.i_req_valid = '0;
   endtask

   task automatic set_req(input int k, input logic [NB_BITS-1:0] a,
                          input logic [NB_BITS-1:0] b, input logic cin);
      bus.i_req_valid[k]                  = 1'b1;
      bus.i_req_a[k*NB_BITS +: NB_BITS]   = a;
      bus.i_req_b[k*NB_BITS +: NB_BITS]   = b;
      bus.i_req_cin[k]                    = cin;
   endtask

   task automatic rand_ops();
      for (int k = 0; k < N_REQ; k++) begin
         bus.i_req_a[k*NB_BITS +: NB_BITS] = NB_BITS'($urandom);
         bus.i_req_b[k*NB_BITS +: NB_BITS] = NB_BITS'($urandom);
         bus.i_req_cin[k]                  = 1'($urandom);
      end
   endtask

   // One clock cycle: check the DUT at the falling edge against the model,
   // update the scoreboard, then return 1 time unit after the rising edge.
   task automatic step();
      logic [N_REQ-1:0] eg;
      logic             stall;
      int               k;
      exp_t             e;
      logic [NB_BITS:0] s;
      @(negedge clk);
      chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(mvalid));
      stall = mvalid && !bus.i_rsp_ready;
      eg = '0;
      k  = -1;
      if (!stall) begin
         for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (mptr + i) % N_REQ;
            if (k < 0 && bus.i_req_valid[j]) k = j;
         end
      end
      if (k >= 0) eg[k] = 1'b1;
      chk("grant", 32'(bus.o_req_ready), 32'(eg));
      if (mvalid) begin
         chk("q_size", 32'(q.size()), 32'd1);
         if (q.size() > 0) begin
            chk("rsp_id", 32'(bus.o_rsp_id), 32'(q[0].id));
            chk("rsp_sum", 32'(bus.o_rsp_sum), 32'(q[0].sum));
            if (!stall) void'(q.pop_front());
         end
      end
      last_grant = k;
      if (k >= 0) begin
         s = {1'b0, bus.i_req_a[k*NB_BITS +: NB_BITS]}
           + {1'b0, bus.i_req_b[k*NB_BITS +: NB_BITS]}
           + {{NB_BITS{1'b0}}, bus.i_req_cin[k]};
         e.id  = ID_W'(k);
         e.sum = s;
         q.push_back(e);
         mptr   = (k + 1) % N_REQ;
         mvalid = 1'b1;
         n_acc++;
      end else if (!stall) begin
         mvalid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc0;
      int saved_ptr;
      bus.i_req_valid = '0;
      bus.i_req_a     = '0;
      bus.i_req_b     = '0;
      bus.i_req_cin   = '0;
      bus.i_rsp_ready = 1'b1;
      #12;
      chk("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
      chk("rst_sum", 32'(bus.o_rsp_sum), 32'd0);
      chk("rst_id", 32'(bus.o_rsp_id), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single request from requester 1
      set_req(1, 16'h1234, 16'h0001, 1'b1);
      step();
      chk("t1_grant", 32'(last_grant), 32'd1);
      chk("t1_sum", 32'(bus.o_rsp_sum), 32'h01236);
      chk("t1_id", 32'(bus.o_rsp_id), 32'd1);
      clear_req();
      step();

      // carry-out
      set_req(0, 16'hFFFF, 16'h0001, 1'b0);
      step();
      chk("cout1", 32'(bus.o_rsp_sum), 32'h10000);
      set_req(0, 16'hFFFF, 16'hFFFF, 1'b1);
      step();
      chk("cout2", 32'(bus.o_rsp_sum), 32'h1FFFF);
      clear_req();
      step();

      // round robin, all valid, no bubbles
      acc0 = n_acc;
      bus.i_req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         rand_ops();
         step();
      end
      chk("rr_accepts", 32'(n_acc - acc0), 32'd8);

      // backpressure for 3 cycles
      saved_ptr = mptr;
      bus.i_rsp_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 3; i++) begin
         rand_ops();
         step();
      end
      chk("bp_accepts", 32'(n_acc - acc0), 32'd0);
      bus.i_rsp_ready = 1'b1;
      step();
      chk("bp_resume", 32'(last_grant), 32'(saved_ptr));

      // pointer wrap: reach a grant to 3, then only 0 and 2 valid
      for (int i = 0; i < N_REQ && last_grant != 3; i++) step();
      chk("wrap_pre", 32'(last_grant), 32'd3);
      bus.i_req_valid = 4'b0101;
      step();
      chk("wrap_0", 32'(last_grant), 32'd0);
      step();
      chk("wrap_2", 32'(last_grant), 32'd2);
      clear_req();
      step();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         bus.i_req_valid = N_REQ'($urandom);
         bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
         rand_ops();
         step();
      end
      bus.i_rsp_ready = 1'b1;
      clear_req();
      step();
      step();

      // reset mid-stream
      bus.i_req_valid = '1;
      rand_ops();
      step();
      chk("mid_valid", 32'(bus.o_rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
      chk("mid_rst_sum", 32'(bus.o_rsp_sum), 32'd0);
      chk("mid_rst_id", 32'(bus.o_rsp_id), 32'd0);
      q.delete();
      mvalid = 1'b0;
      mptr   = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      chk("post_rst_grant", 32'(last_grant), 32'd0);
      clear_req();
      step();
      step();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
